gcd_engine: RTL



---
 rtl/gcd_engine.sv | 107 ++++++++++
 1 files changed

// File: rtl/gcd_engine.sv
// Iterative GCD unit (subtractive Euclid or binary Stein) with valid/ready on both sides.
// Results and cycle count stay registered until the consumer takes them.
module gcd_engine #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ALGO  = 0,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic [CNT_W-1:0] cycles_out,
  output logic             zero_err
);

  localparam int unsigned KW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [KW-1:0]    k_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;

  // Counter saturates; the computation itself keeps going.
  always_comb begin
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      gcd_out    <= '0;
      cycles_out <= '0;
      zero_err   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q   <= a_in;
            b_q   <= b_in;
            k_q   <= '0;
            cnt_q <= '0;
            if ((a_in == '0) || (b_in == '0)) begin
              gcd_out    <= a_in | b_in;
              zero_err   <= (a_in == '0) && (b_in == '0);
              cycles_out <= '0;
              state_q    <= StDone;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          cnt_q <= cnt_inc;
          if (a_q == b_q) begin
            // Shift back the common power of two removed by Stein; always fits.
            gcd_out    <= (ALGO == 0) ? a_q : (a_q << k_q);
            cycles_out <= cnt_inc;
            zero_err   <= 1'b0;
            state_q    <= StDone;
          end else if (ALGO == 0) begin
            if (a_q > b_q) begin
              a_q <= a_q - b_q;
            end else begin
              b_q <= b_q - a_q;
            end
          end else begin
            if (!a_q[0] && !b_q[0]) begin
              a_q <= a_q >> 1;
              b_q <= b_q >> 1;
              k_q <= k_q + KW'(1);
            end else if (!a_q[0]) begin
              a_q <= a_q >> 1;
            end else if (!b_q[0]) begin
              b_q <= b_q >> 1;
            end else if (a_q > b_q) begin
              a_q <= (a_q - b_q) >> 1;
            end else begin
              b_q <= (b_q - a_q) >> 1;
            end
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
